mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_if.sv | 32 +++
 rtl/mul_div_unit.sv | 147 ++++++++++++++
 tb/tb_mul_div_unit.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_if
// Description : Request/result bus between the pipeline and the mul/div unit.
// Revision    : 1.0
// ============================================================================
interface mul_div_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             HiWrite;
    logic             LoWrite;
    logic [WIDTH-1:0] WData;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output Start, Op, A, B, HiWrite, LoWrite, WData,
        input  Busy, Done, HI, LO
    );

    modport slave (
        input  Start, Op, A, B, HiWrite, LoWrite, WData,
        output Busy, Done, HI, LO
    );
endinterface
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Iterative HI/LO multiply/divide unit, one bit per clock.
// Revision    : 1.0
// ============================================================================
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  wire logic clk,
    input  wire logic rst_n,
    mul_div_if.slave  bus
);
    localparam int                c_cnt_w    = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_wrk;
    logic [WIDTH-1:0]   r_opb;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [WIDTH:0]     w_msum;
    logic [WIDTH:0]     w_rshift;
    logic [WIDTH+1:0]   w_rdiff;
    logic               w_fit;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_signed = ~bus.Op[0];
    assign w_a_neg  = w_signed & bus.A[WIDTH-1];
    assign w_b_neg  = w_signed & bus.B[WIDTH-1];
    assign w_a_abs  = w_a_neg ? -bus.A : bus.A;
    assign w_b_abs  = w_b_neg ? -bus.B : bus.B;

    // Multiply: {acc,wrk} shifts right, adding the multiplicand when wrk[0] is set.
    assign w_msum   = {1'b0, r_acc} + (r_wrk[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
    // Divide: acc is the partial remainder, wrk shifts the dividend out and the quotient in.
    assign w_rshift = {r_acc, r_wrk[WIDTH-1]};
    assign w_rdiff  = {1'b0, w_rshift} - {2'b00, r_opb};
    assign w_fit    = ~w_rdiff[WIDTH+1];

    assign w_prod     = {r_acc, r_wrk};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    // A zero divisor never borrows, so acc ends as |A|; restoring its sign yields A.
    assign w_quo_fix  = r_dz ? {WIDTH{1'b1}} : (r_neg_q ? -r_wrk : r_wrk);
    assign w_rem_fix  = r_neg_r ? -r_acc : r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.Start) w_state_nxt = S_CALC;
            S_CALC:  if (r_cnt == c_cnt_last) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_acc    <= '0;
            r_wrk    <= '0;
            r_opb    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == S_FIN);
            case (r_state)
                S_IDLE: begin
                    if (bus.HiWrite) r_hi <= bus.WData;
                    if (bus.LoWrite) r_lo <= bus.WData;
                    if (bus.Start) begin
                        r_cnt    <= '0;
                        r_is_div <= bus.Op[1];
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_dz     <= bus.Op[1] && (bus.B == '0);
                        r_acc    <= '0;
                        r_wrk    <= w_a_abs;
                        r_opb    <= w_b_abs;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_is_div) begin
                        r_acc <= w_fit ? w_rdiff[WIDTH-1:0] : w_rshift[WIDTH-1:0];
                        r_wrk <= {r_wrk[WIDTH-2:0], w_fit};
                    end else begin
                        r_acc <= w_msum[WIDTH:1];
                        r_wrk <= {w_msum[0], r_wrk[WIDTH-1:1]};
                    end
                end
                S_FIN: begin
                    if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Busy = (r_state != S_IDLE);
    assign bus.Done = r_done;
    assign bus.HI   = r_hi;
    assign bus.LO   = r_lo;
endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Self-checking bench for mul_div_unit (vectors, random, corners).
// Revision    : 1.0
// ============================================================================
module tb_mul_div_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    mul_div_if #(.WIDTH(32)) bus ();

    mul_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference behaviour from plain 64-bit arithmetic.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint sa;
        longint sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: p = 64'(sa * sb);
            2'b01: p = {32'b0, a} * {32'b0, b};
            2'b10: p = (b == 0) ? {a, 32'hFFFFFFFF} : {32'(sa % sb), 32'(sa / sb)};
            default: p = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
        endcase
        hi = p[63:32];
        lo = p[31:0];
    endfunction

    // All tasks are entered and left at a falling edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        bus.Start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input logic [31:0] ehi, input logic [31:0] elo);
        int e;
        e = 0;
        while (!bus.Done && e < 60) begin
            @(negedge clk);
            e++;
        end
        check({nm, "_latency"}, 64'(e), 64'd33);
        check({nm, "_hi"}, {32'b0, bus.HI}, {32'b0, ehi});
        check({nm, "_lo"}, {32'b0, bus.LO}, {32'b0, elo});
        check({nm, "_busy_at_done"}, {63'b0, bus.Busy}, 64'd0);
    endtask

    task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        issue(op, a, b);
        check({nm, "_busy"}, {63'b0, bus.Busy}, 64'd1);
        wait_done(nm, ehi, elo);
    endtask

    task automatic count_dones(input string nm, input int cycles);
        int n;
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.Done) n++;
        end
        check(nm, 64'(n), 64'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  rop;
        logic [31:0] mhi;
        logic [31:0] mlo;
        logic [31:0] lo_before;
        int          e;

        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        bus.Start   = 1'b0;
        bus.Op      = 2'b00;
        bus.A       = '0;
        bus.B       = '0;
        bus.HiWrite = 1'b0;
        bus.LoWrite = 1'b0;
        bus.WData   = '0;

        vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{2'b11, 32'd100,      32'h00000000, 32'h00000064, 32'hFFFFFFFF};
        vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[6]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[7]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[8]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[9]  = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[10] = '{2'b00, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};

        repeat (3) @(negedge clk);
        check("reset_busy", {63'b0, bus.Busy}, 64'd0);
        check("reset_done", {63'b0, bus.Done}, 64'd0);
        check("reset_hi", {32'b0, bus.HI}, 64'd0);
        check("reset_lo", {32'b0, bus.LO}, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

        for (int i = 0; i < 20; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb & 32'h000000FF;
            model(rop, ra, rb, mhi, mlo);
            run_op($sformatf("rand%0d", i), rop, ra, rb, mhi, mlo);
        end

        // Direct writes in IDLE.
        bus.HiWrite = 1'b1;
        bus.WData   = 32'h1234;
        @(negedge clk);
        bus.HiWrite = 1'b0;
        check("hiwrite", {32'b0, bus.HI}, 64'h1234);
        bus.LoWrite = 1'b1;
        bus.WData   = 32'h5678;
        @(negedge clk);
        bus.LoWrite = 1'b0;
        check("lowrite", {32'b0, bus.LO}, 64'h5678);
        check("lowrite_hi_hold", {32'b0, bus.HI}, 64'h1234);

        // Start and write ignored while busy.
        issue(2'b01, 32'd3, 32'd5);
        lo_before = bus.LO;
        e = 0;
        repeat (10) begin @(negedge clk); e++; end
        bus.Start = 1'b1;
        bus.Op    = 2'b01;
        bus.A     = 32'd9;
        bus.B     = 32'd9;
        @(negedge clk); e++;
        bus.Start   = 1'b0;
        bus.LoWrite = 1'b1;
        bus.WData   = 32'hAAAA;
        @(negedge clk); e++;
        bus.LoWrite = 1'b0;
        check("busy_lowrite_ignored", {32'b0, bus.LO}, {32'b0, lo_before});
        while (!bus.Done && e < 60) begin @(negedge clk); e++; end
        check("busy_seq_latency", 64'(e), 64'd33);
        check("busy_seq_lo", {32'b0, bus.LO}, 64'd15);
        check("busy_seq_hi", {32'b0, bus.HI}, 64'd0);
        count_dones("busy_seq_extra_done", 40);

        // Start in the Done cycle is accepted.
        run_op("b2b_first", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42);
        run_op("b2b_second", 2'b11, 32'd1000, 32'd7, 32'd6, 32'd142);

        // Start together with a direct write.
        bus.HiWrite = 1'b1;
        bus.WData   = 32'hCAFE;
        issue(2'b01, 32'd2, 32'd3);
        bus.HiWrite = 1'b0;
        check("start_wr_hi", {32'b0, bus.HI}, 64'hCAFE);
        check("start_wr_busy", {63'b0, bus.Busy}, 64'd1);
        wait_done("start_wr", 32'd0, 32'd6);

        // Asynchronous reset mid-operation.
        bus.HiWrite = 1'b1;
        bus.LoWrite = 1'b1;
        bus.WData   = 32'h1111;
        @(negedge clk);
        bus.HiWrite = 1'b0;
        bus.LoWrite = 1'b0;
        issue(2'b11, 32'd1000, 32'd3);
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", {63'b0, bus.Busy}, 64'd0);
        check("async_rst_done", {63'b0, bus.Done}, 64'd0);
        check("async_rst_hi", {32'b0, bus.HI}, 64'd0);
        check("async_rst_lo", {32'b0, bus.LO}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_dones("after_rst_no_done", 40);
        check("after_rst_hi_hold", {32'b0, bus.HI}, 64'd0);

        // First edge after reset release accepts Start.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op("first_after_rst", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
